// File: rtl/serial_rx_framed_pkg.sv
// Receiver types built on the shared serial_defs.vh encodings.
// SERIAL_RX_PARITY_EN adds the PARITY state.
`include "serial_defs.vh"

package serial_rx_framed_pkg;

    typedef enum logic [2:0] {
        IDLE   = `SERIAL_ST_IDLE,
        START  = `SERIAL_ST_START,
        DATA   = `SERIAL_ST_DATA,
`ifdef SERIAL_RX_PARITY_EN
        PARITY = `SERIAL_ST_PARITY,
`endif
        STOP   = `SERIAL_ST_STOP,
        BREAK  = `SERIAL_ST_BREAK
    } rx_state_e;

    typedef struct packed {
        logic ferr;
        logic perr;
        logic brk;
    } rx_flags_t;

endpackage

// File: rtl/serial_baud_timer.sv
// Baud down-counter: explicit load, holds at zero, combinational zero flag.
module serial_baud_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/serial_defs.vh
// Shared serial definitions: FSM state encodings and the baud divisor macro,
// common to the serial receiver and transmitter.
`ifndef SERIAL_DEFS_VH
`define SERIAL_DEFS_VH

`define SERIAL_BAUD_CLKS(clk_freq, baud_rate) ((clk_freq) / (baud_rate))

`define SERIAL_ST_IDLE   3'd0
`define SERIAL_ST_START  3'd1
`define SERIAL_ST_DATA   3'd2
`define SERIAL_ST_PARITY 3'd3
`define SERIAL_ST_STOP   3'd4
`define SERIAL_ST_BREAK  3'd5

`endif

// File: rtl/serial_rx_framed.sv
// Framed UART receiver: 2-flop sync, mid-bit sampling, ferr/perr/break flags.
// Define SERIAL_RX_PARITY_EN to add a parity bit (ODD_PARITY selects sense).
`include "serial_defs.vh"

module serial_rx_framed
    import serial_rx_framed_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 48_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    output logic                 o_wr,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_ferr,
    output logic                 o_perr,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int unsigned BAUD_CLKS = `SERIAL_BAUD_CLKS(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W     = $clog2(BAUD_CLKS);
    localparam int unsigned IDX_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_CLKS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_CLKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    if (BAUD_CLKS < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || ODD_PARITY > 1) begin : g_param_check
        $error("serial_rx_framed: illegal parameter set");
    end

    rx_state_e            state, state_n;
    logic                 rx_meta, rx_s;
    logic                 tmr_load, tmr_zero_c;
    logic [CNT_W-1:0]     tmr_val;
    logic                 shift_en, stop_en, done;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx, stop_low_q;
    logic [DATA_BITS-1:0] data_sh;
    logic                 last_bit, last_stop, ferr_now, brk_now, perr_now;
    rx_flags_t            flags_q;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic ODD_BIT = (ODD_PARITY != 0);
    logic par_en, perr_q;
`endif

    // Line synchronizer, idles high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    serial_baud_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    assign last_bit  = (bit_idx == LAST_IDX);
    assign last_stop = (stop_idx == LAST_STOP);
    assign ferr_now  = !rx_s | (stop_idx & stop_low_q);
    assign brk_now   = (data_sh == '0) & (stop_idx ? stop_low_q : !rx_s);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (!rx_s) state_n = START;
            START:  if (tmr_zero_c) state_n = rx_s ? IDLE : DATA;
`ifdef SERIAL_RX_PARITY_EN
            DATA:   if (tmr_zero_c && last_bit) state_n = PARITY;
            PARITY: if (tmr_zero_c) state_n = STOP;
`else
            DATA:   if (tmr_zero_c && last_bit) state_n = STOP;
`endif
            STOP:   if (tmr_zero_c && last_stop) state_n = brk_now ? BREAK : IDLE;
            BREAK:  if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = FULL_LOAD;
        shift_en = 1'b0;
        stop_en  = 1'b0;
        done     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_en   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    tmr_load = 1'b1;
                    tmr_val  = HALF_LOAD;
                end
            end
            START:  tmr_load = tmr_zero_c && !rx_s;
            DATA: begin
                tmr_load = tmr_zero_c;
                shift_en = tmr_zero_c;
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                tmr_load = tmr_zero_c;
                par_en   = tmr_zero_c;
            end
`endif
            STOP: begin
                stop_en  = tmr_zero_c;
                tmr_load = tmr_zero_c && !last_stop;
                done     = tmr_zero_c && last_stop;
            end
            default: ;
        endcase
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    perr_q <= 1'b0;
        else if (par_en) perr_q <= (^data_sh) ^ rx_s ^ ODD_BIT;
    end
    assign perr_now = perr_q;
`else
    assign perr_now = 1'b0;
`endif

    // Frame datapath: LSB-first shift, bit/stop indices, stop-low memory
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_sh    <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            stop_low_q <= 1'b0;
        end else begin
            if (shift_en) begin
                data_sh <= {rx_s, data_sh[DATA_BITS-1:1]};
                bit_idx <= last_bit ? '0 : bit_idx + IDX_W'(1);
            end
            if (stop_en) begin
                stop_idx <= last_stop ? 1'b0 : 1'b1;
                if (!stop_idx) stop_low_q <= !rx_s;
            end
        end
    end

    // Delivered word and flags hold until the next frame completes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr    <= 1'b0;
            o_data  <= '0;
            flags_q <= '0;
            o_busy  <= 1'b0;
        end else begin
            o_wr   <= done;
            o_busy <= (state_n != IDLE);
            if (done) begin
                o_data  <= data_sh;
                flags_q <= '{ferr: ferr_now, perr: perr_now, brk: brk_now};
            end
        end
    end

    assign o_ferr  = flags_q.ferr;
    assign o_perr  = flags_q.perr;
    assign o_break = flags_q.brk;

endmodule
